// File: rtl/iq_demod_pkg.sv
// Shared types and constants for the IQ demodulator pair sequencer.
package iq_demod_pkg;

  typedef enum logic {
    FILL = 1'b0,
    SEQ  = 1'b1
  } state_t;

  localparam int         NPAIR_C        = 5;
  localparam int         BANK_ENTRIES_C = 2 * NPAIR_C;
  localparam logic [2:0] SEL_LAST_C     = 3'd4;

endpackage

// File: rtl/iq_sample_bank.sv
// Sample register file: sequential write port with occupancy count, bulk
// load port, and a full flag.
module iq_sample_bank
  import iq_demod_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int ENTRIES = BANK_ENTRIES_C
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [SIZE-1:0]           wr_data,
  input  logic                      clear,
  input  logic                      load_en,
  input  logic [ENTRIES*SIZE-1:0]   load_data,
  output logic [ENTRIES*SIZE-1:0]   data,
  output logic [3:0]                count,
  output logic                      full
);

  logic [SIZE-1:0] mem [ENTRIES];

  assign full = (count == 4'(ENTRIES));

  for (genvar k = 0; k < ENTRIES; k++) begin : g_pack
    assign data[k*SIZE +: SIZE] = mem[k];
  end

  // NOTE: the entries are reset as well, because the bank is an observable
  // output that must read zero after reset; this is a small flop array, not RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int k = 0; k < ENTRIES; k++) mem[k] <= '0;
    end else begin
      // NOTE: sequential state is always updated with non-blocking assignments
      // so every flop samples pre-edge values regardless of statement order.
      if (clear)
        count <= '0;
      else if (wr_en && !full)
        count <= count + 4'd1;

      if (load_en) begin
        for (int k = 0; k < ENTRIES; k++) mem[k] <= load_data[k*SIZE +: SIZE];
      end else if (wr_en && !full) begin
        mem[count] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/iq_pair_sequencer.sv
// Collects 10 serial samples into an I/Q bank and steps the pair select 0..4
// under valid/ready. Optional double buffering: define IQ_PAIR_SEQ_DBUF_EN.
module iq_pair_sequencer
  import iq_demod_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int NPAIR = NPAIR_C
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE-1:0]           s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [2*NPAIR*SIZE-1:0]   bank,
  output logic [2:0]                sel,
  output logic                      pair_valid,
  input  logic                      pair_ready,
  output logic                      frame_done,
  output logic [3:0]                fill_cnt
);

  localparam int ENTRIES = 2 * NPAIR;

  state_t state;
  logic   xfer;
  logic   last_pair;
  logic   completing;
  logic   refill;
  logic   ready_next;

  assign xfer      = s_valid && s_ready;
  assign last_pair = pair_valid && pair_ready && (sel == SEL_LAST_C);

`ifdef IQ_PAIR_SEQ_DBUF_EN
  logic [ENTRIES*SIZE-1:0] shadow_data;
  logic [ENTRIES*SIZE-1:0] image;
  logic [3:0]              bank_cnt;
  logic                    bank_full;
  logic                    shadow_full;
  logic                    shadow_wr;
  logic                    load;

  assign shadow_wr  = xfer && !shadow_full;
  assign completing = shadow_full || (shadow_wr && fill_cnt == 4'(ENTRIES - 1));
  assign load       = completing && ((state == FILL) || last_pair);
  assign refill     = completing;
  assign ready_next = load || !completing;

  // NOTE: give every always_comb output a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    image = shadow_data;
    if (shadow_wr && fill_cnt == 4'(ENTRIES - 1))
      image[(ENTRIES-1)*SIZE +: SIZE] = s_data;
  end

  iq_sample_bank #(.SIZE(SIZE), .ENTRIES(ENTRIES)) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (shadow_wr),
    .wr_data   (s_data),
    .clear     (load),
    .load_en   (1'b0),
    .load_data ('0),
    .data      (shadow_data),
    .count     (fill_cnt),
    .full      (shadow_full)
  );

  // Presented bank only changes by a whole-bank copy, so it never moves mid-frame.
  iq_sample_bank #(.SIZE(SIZE), .ENTRIES(ENTRIES)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (1'b0),
    .wr_data   ('0),
    .clear     (1'b0),
    .load_en   (load),
    .load_data (image),
    .data      (bank),
    .count     (bank_cnt),
    .full      (bank_full)
  );
`else
  logic bank_full;
  logic bank_wr;

  assign bank_wr    = xfer && !bank_full;
  assign completing = bank_wr && (fill_cnt == 4'(ENTRIES - 1));
  assign refill     = 1'b0;
  assign ready_next = (state == FILL) ? !completing : last_pair;

  iq_sample_bank #(.SIZE(SIZE), .ENTRIES(ENTRIES)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (bank_wr),
    .wr_data   (s_data),
    .clear     (last_pair),
    .load_en   (1'b0),
    .load_data ('0),
    .data      (bank),
    .count     (fill_cnt),
    .full      (bank_full)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      sel        <= '0;
      pair_valid <= 1'b0;
      frame_done <= 1'b0;
      s_ready    <= 1'b0;
    end else begin
      frame_done <= last_pair;
      s_ready    <= ready_next;
      case (state)
        FILL: begin
          if (completing) begin
            state      <= SEQ;
            pair_valid <= 1'b1;
            sel        <= '0;
          end
        end
        SEQ: begin
          if (pair_valid && pair_ready) begin
            if (sel == SEL_LAST_C) begin
              sel <= '0;
              // With a full shadow the next frame follows with no valid gap.
              if (refill) begin
                pair_valid <= 1'b1;
              end else begin
                pair_valid <= 1'b0;
                state      <= FILL;
              end
            end else begin
              sel <= sel + 3'd1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/iq_pair_sequencer.md
Name: iq_pair_sequencer

Overview:
- Upstream stage of the IQ demodulator pair-select mux.
- Collects a serial stream of signed samples into a 10-entry bank. The bank is ordered I0,Q0,I1,Q1,...,I4,Q4.
- Presents the bank on parallel outputs and steps the 3-bit pair select 0..4, one pair per accepted handshake, with valid/ready towards the downstream correlator.
- Raises upstream backpressure while a bank is being sequenced.

Parameters:
- SIZE, 8, sample width in bits (two's complement).
- NPAIR, 5, pairs per bank; the bank holds 2*NPAIR entries. Only 5 is supported; the select range is fixed 0..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  SIZE  incoming sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block accepts a sample this cycle.
- bank  out  10*SIZE  packed bank; slice k = entry k = in_k of the mux.
- sel  out  3  current pair index, 0..4.
- pair_valid  out  1  bank/sel pair valid for the downstream stage.
- pair_ready  in  1  downstream consumed the current pair.
- frame_done  out  1  one-cycle pulse after pair 4 is consumed.
- fill_cnt  out  4  entries written into the fill bank, 0..10.

Behaviour:
- Reset values (asynchronous, all outputs and state): bank=0, sel=0, pair_valid=0, frame_done=0, fill_cnt=0, state=FILL, s_ready=1 one cycle after reset deasserts.
- Sample transfer: occurs when s_valid && s_ready at the clk edge. The sample is written to entry fill_cnt, then fill_cnt increments.
- FILL state:
  - s_ready=1, pair_valid=0.
  - On the transfer that writes entry 9: fill_cnt goes to 10, state goes to SEQ on the next edge, sel=0.
- SEQ state:
  - s_ready=0 (without the optional feature).
  - pair_valid=1 and sel are registered.
  - On pair_valid && pair_ready: sel increments.
  - If sel was 4: sel returns to 0, pair_valid=0, frame_done pulses for 1 cycle, fill_cnt=0, state=FILL.
- Latency: pair_valid rises 1 cycle after the 10th sample transfer.
- Bank stability: bank must stay stable whenever pair_valid=1.
- Back-to-back throughput: a full bank drains in 5 cycles. The next fill can start the cycle after frame_done.
- pair_ready stall: sel and bank hold while pair_ready=0; pair_valid is never dropped without a handshake.
- s_valid=0 mid-fill: fill_cnt holds; no timeout.
- fill_cnt never exceeds 10; sel never exceeds 4.
- Reset mid-fill or mid-sequence: everything returns to reset values immediately and a partial bank is discarded. No frame_done is generated for an aborted bank.
- sel uses only values 0..4; 5..7 are never driven.

Optional Feature:
- Macro: IQ_PAIR_SEQ_DBUF_EN.
- With the macro defined:
  - A second (shadow) bank is added, and s_ready stays 1 during SEQ while the shadow is not full.
  - Samples fill the shadow; fill_cnt reports shadow occupancy.
  - At the frame_done edge, if the shadow is full: shadow copies to bank, fill_cnt=0, state stays SEQ, sel=0, pair_valid=1 next cycle with no gap.
  - If the shadow is not full at frame_done, state goes to FILL and filling continues with the occupancy retained.
  - Shadow full during SEQ: s_ready=0.
- Without the macro: single bank; behaviour exactly as above.

Decomposition:
- Shared package iq_demod_pkg:
  - state enum (FILL, SEQ)
  - NPAIR_C=5
  - BANK_ENTRIES_C=10
  - SEL_LAST_C=3'd4
- Sub-module iq_sample_bank: 10-entry register file with write index/enable and a full flag. It is instantiated twice under IQ_PAIR_SEQ_DBUF_EN.

Test Plan:
- Reset, then 10 samples 1..10 with s_valid held high -> pair_valid=1 one cycle after the 10th; bank slices = 1..10; sel=0; s_ready=0.
- pair_ready held high after the fill -> sel steps 0,1,2,3,4 on consecutive cycles; frame_done pulses once; s_ready=1 the next cycle; fill_cnt=0.
- pair_ready=0 for 3 cycles at sel=2 -> sel and bank stable, pair_valid stays 1; sel goes to 3 on the first cycle pair_ready=1.
- s_valid gaps (pattern 1,0,0,1,...) during fill -> fill_cnt increments only on transfers; bank order preserved; samples -128 and 127 stored exactly.
- rst asserted asynchronously at fill_cnt=6, and again at sel=3 -> outputs go to 0 immediately, no frame_done; the next bank of 10 sequences normally.
- IQ_PAIR_SEQ_DBUF_EN: stream 20 samples continuously with pair_ready=1 -> two banks sequenced back-to-back, sel 0..4, 0..4 with no pair_valid gap; second bank = samples 11..20.
